// File: rtl/ecc_apb_engine_if.sv
// ecc_apb_engine_if: APB slave bus bundle for the ECC engine.
interface ecc_apb_engine_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;
    modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/ecc_apb_engine.sv
// ecc_apb_engine: APB-programmed extended-Hamming encoder/decoder for 8/16/32-bit codewords.
module ecc_apb_engine #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    ecc_apb_engine_if.slave       apb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENC  = 2'd1;
    localparam logic [1:0] S_DEC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Position number of data bit j: 3,5,6,7,9..15,17..31
    function automatic logic [4:0] f_pos(input int j);
        return 5'(j < 1 ? 3 : j < 4 ? j + 4 : j < 11 ? j + 5 : j + 6);
    endfunction

    // Parity vector is the XOR of the position numbers of all set data bits
    function automatic logic [4:0] f_par(input logic [25:0] d);
        logic [4:0] c;
        c = '0;
        for (int j = 0; j < 26; j++) c = c ^ (d[j] ? f_pos(j) : 5'd0);
        return c;
    endfunction

    function automatic logic [31:0] f_wmask(input logic [1:0] s);
        return s == 2'd0 ? 32'h0000_00FF : s == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] f_kmask(input logic [1:0] s);
        return s == 2'd0 ? 32'h0000_000F : s == 2'd1 ? 32'h0000_07FF : 32'h03FF_FFFF;
    endfunction

    logic [1:0]           r_state;
    logic [AMBA_WORD-1:0] r_ctrl;
    logic [AMBA_WORD-1:0] r_din;
    logic [AMBA_WORD-1:0] r_cwsel;
    logic [AMBA_WORD-1:0] r_noise;
    logic [1:0]           r_mode;
    logic [1:0]           r_wsel;
    logic [31:0]          r_work;
    logic [31:0]          r_nz;

    logic        w_wr;
    logic        w_idle;
    logic        w_wr_ok;
    logic [1:0]  w_addr;
    logic [25:0] w_ed;
    logic [4:0]  w_ec;
    logic        w_eov;
    logic [31:0] w_cw;
    logic [25:0] w_rd;
    logic [4:0]  w_rc;
    logic [4:0]  w_syn;
    logic        w_dov;
    logic [25:0] w_flip;
    logic [1:0]  w_nerr;
    logic [25:0] w_dec;
    logic        w_unused;

    assign w_wr     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_idle   = r_state == S_IDLE;
    assign w_wr_ok  = w_wr & w_idle;
    assign w_addr   = apb.PADDR[3:2];
    assign w_unused = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:4], apb.PADDR[1:0]};

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_wr & ~w_idle;
    assign apb.PRDATA  = (apb.PSEL && !apb.PWRITE) ?
                         (w_addr == 2'd0 ? r_ctrl : w_addr == 2'd1 ? r_din : w_addr == 2'd2 ? r_cwsel : r_noise) : '0;

    assign operation_done = r_state == S_DONE;

    // Encoder works on r_work already masked to K data bits
    assign w_ed  = r_work[25:0];
    assign w_ec  = f_par(w_ed);
    assign w_eov = ^{w_ed, w_ec};
    assign w_cw  = r_wsel == 2'd0 ? {24'd0, w_eov, w_ec[2:0], w_ed[3:0]} :
                   r_wsel == 2'd1 ? {16'd0, w_eov, w_ec[3:0], w_ed[10:0]} :
                                    {w_eov, w_ec, w_ed};

    // Decoder works on r_work already masked to W codeword bits
    assign w_rd  = r_wsel == 2'd0 ? {22'd0, r_work[3:0]} : r_wsel == 2'd1 ? {15'd0, r_work[10:0]} : r_work[25:0];
    assign w_rc  = r_wsel == 2'd0 ? {2'd0, r_work[6:4]} : r_wsel == 2'd1 ? {1'b0, r_work[14:11]} : r_work[30:26];
    assign w_syn = w_rc ^ f_par(w_rd);
    assign w_dov = ^r_work;

    always_comb begin
        w_flip = '0;
        for (int j = 0; j < 26; j++) w_flip[j] = f_pos(j) == w_syn;
    end

    assign w_nerr = w_dov ? 2'b01 : (w_syn != 5'd0 ? 2'b10 : 2'b00);
    assign w_dec  = w_nerr == 2'b10 ? 26'd0 : w_rd ^ (w_dov ? w_flip : 26'd0);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= S_IDLE;
            r_ctrl        <= '0;
            r_din         <= '0;
            r_cwsel       <= '0;
            r_noise       <= '0;
            r_mode        <= '0;
            r_wsel        <= '0;
            r_work        <= '0;
            r_nz          <= '0;
            data_out      <= '0;
            num_of_errors <= '0;
        end else begin
            if (w_wr_ok && w_addr == 2'd0) r_ctrl <= apb.PWDATA;
            if (w_wr_ok && w_addr == 2'd1) r_din <= apb.PWDATA;
            if (w_wr_ok && w_addr == 2'd2) r_cwsel <= apb.PWDATA;
            if (w_wr_ok && w_addr == 2'd3) r_noise <= apb.PWDATA;
            case (r_state)
                S_IDLE: if (w_wr_ok && w_addr == 2'd0) begin
                    r_mode  <= apb.PWDATA[1:0];
                    r_wsel  <= r_cwsel[1:0];
                    r_nz    <= r_noise[31:0] & f_wmask(r_cwsel[1:0]);
                    r_work  <= r_din[31:0] & (apb.PWDATA[1:0] == 2'b01 ? f_wmask(r_cwsel[1:0]) : f_kmask(r_cwsel[1:0]));
                    r_state <= apb.PWDATA[1:0] == 2'b01 ? S_DEC : S_ENC;
                end
                S_ENC: if (r_mode == 2'b00) begin
                    data_out      <= DATA_WIDTH'(w_cw);
                    num_of_errors <= 2'b00;
                    r_state       <= S_DONE;
                end else begin
                    r_work  <= w_cw ^ r_nz;
                    r_state <= S_DEC;
                end
                S_DEC: begin
                    data_out      <= DATA_WIDTH'(w_dec);
                    num_of_errors <= w_nerr;
                    r_state       <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_apb_engine.sv
// tb_ecc_apb_engine: directed-vector bench for the APB ECC engine.
module tb_ecc_apb_engine;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b1;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    int          n_tests = 0;
    int          n_fail = 0;

    ecc_apb_engine_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb();

    ecc_apb_engine #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32)) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .apb(apb),
        .data_out(data_out),
        .operation_done(operation_done),
        .num_of_errors(num_of_errors)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_bus();
        apb.PSEL = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE = 1'b0;
        apb.PADDR = '0;
        apb.PWDATA = '0;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        apb.PADDR = 20'(a);
        apb.PWDATA = d;
        apb.PWRITE = 1'b1;
        apb.PSEL = 1'b1;
        apb.PENABLE = 1'b0;
        @(posedge PCLK); #1 apb.PENABLE = 1'b1;
        @(posedge PCLK); #1 idle_bus();
    endtask

    task automatic apb_access(input logic [3:0] a, input logic [31:0] d, output logic err);
        apb.PADDR = 20'(a);
        apb.PWDATA = d;
        apb.PWRITE = 1'b1;
        apb.PSEL = 1'b1;
        apb.PENABLE = 1'b1;
        #1 err = apb.PSLVERR;
        @(posedge PCLK); #1 idle_bus();
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
        apb.PADDR = 20'(a);
        apb.PWRITE = 1'b0;
        apb.PSEL = 1'b1;
        apb.PENABLE = 1'b0;
        #1 d = apb.PRDATA;
        @(posedge PCLK); #1 apb.PENABLE = 1'b1;
        #1 err = apb.PSLVERR;
        @(posedge PCLK); #1 idle_bus();
    endtask

    task automatic start_op(input logic [31:0] cw, input logic [31:0] nz, input logic [31:0] din, input logic [31:0] ctrl);
        apb_write(4'h8, cw);
        apb_write(4'hC, nz);
        apb_write(4'h4, din);
        apb_write(4'h0, ctrl);
    endtask

    task automatic test_reset();
        idle_bus();
        #2 PRESETn = 1'b0;
        #1;
        n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp %h", data_out, 32'h0); end
        n_tests++; if (num_of_errors !== 2'b00) begin n_fail++; $display("FAIL reset_num_err got %b exp %b", num_of_errors, 2'b00); end
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp %b", operation_done, 1'b0); end
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 20'h4; apb.PWDATA = 32'hDEAD;
        #1;
        n_tests++; if (apb.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b exp %b", apb.PSLVERR, 1'b0); end
        n_tests++; if (apb.PRDATA !== 32'h0) begin n_fail++; $display("FAIL write_prdata got %h exp %h", apb.PRDATA, 32'h0); end
        apb.PWRITE = 1'b0;
        #1;
        n_tests++; if (apb.PRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_datain_reg got %h exp %h", apb.PRDATA, 32'h0); end
        idle_bus();
        @(negedge PCLK) PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_encode();
        start_op(32'h0, 32'h0, 32'hB, 32'h0);
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL enc8_early_done got %b exp %b", operation_done, 1'b0); end
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b1) begin n_fail++; $display("FAIL enc8_done got %b exp %b", operation_done, 1'b1); end
        n_tests++; if (data_out !== 32'h1B) begin n_fail++; $display("FAIL enc8_data got %h exp %h", data_out, 32'h1B); end
        n_tests++; if (num_of_errors !== 2'b00) begin n_fail++; $display("FAIL enc8_nerr got %b exp %b", num_of_errors, 2'b00); end
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL enc8_pulse got %b exp %b", operation_done, 1'b0); end
        n_tests++; if (data_out !== 32'h1B) begin n_fail++; $display("FAIL enc8_hold got %h exp %h", data_out, 32'h1B); end
        start_op(32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0);
        @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'hFFFF) begin n_fail++; $display("FAIL enc16_data got %h exp %h", data_out, 32'hFFFF); end
    endtask

    task automatic test_decode();
        start_op(32'h0, 32'h0, 32'h1B, 32'h1);
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b1) begin n_fail++; $display("FAIL dec8_done got %b exp %b", operation_done, 1'b1); end
        n_tests++; if (data_out !== 32'hB) begin n_fail++; $display("FAIL dec8_data got %h exp %h", data_out, 32'hB); end
        n_tests++; if (num_of_errors !== 2'b00) begin n_fail++; $display("FAIL dec8_nerr got %b exp %b", num_of_errors, 2'b00); end
        start_op(32'h0, 32'h0, 32'hFFFF_FF1B, 32'h1);
        @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'hB) begin n_fail++; $display("FAIL dec8_upper_data got %h exp %h", data_out, 32'hB); end
        n_tests++; if (num_of_errors !== 2'b00) begin n_fail++; $display("FAIL dec8_upper_nerr got %b exp %b", num_of_errors, 2'b00); end
        start_op(32'h1, 32'h0, 32'hFFFE, 32'h1);
        @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'h7FF) begin n_fail++; $display("FAIL dec16_dbit_data got %h exp %h", data_out, 32'h7FF); end
        n_tests++; if (num_of_errors !== 2'b01) begin n_fail++; $display("FAIL dec16_dbit_nerr got %b exp %b", num_of_errors, 2'b01); end
        start_op(32'h1, 32'h0, 32'hF7FF, 32'h1);
        @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'h7FF) begin n_fail++; $display("FAIL dec16_pbit_data got %h exp %h", data_out, 32'h7FF); end
        n_tests++; if (num_of_errors !== 2'b01) begin n_fail++; $display("FAIL dec16_pbit_nerr got %b exp %b", num_of_errors, 2'b01); end
        start_op(32'h2, 32'h0, 32'h3, 32'h1);
        @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL dec32_double_data got %h exp %h", data_out, 32'h0); end
        n_tests++; if (num_of_errors !== 2'b10) begin n_fail++; $display("FAIL dec32_double_nerr got %b exp %b", num_of_errors, 2'b10); end
    endtask

    task automatic test_full();
        start_op(32'h0, 32'h1, 32'hB, 32'h2);
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL full8_done0 got %b exp %b", operation_done, 1'b0); end
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL full8_done1 got %b exp %b", operation_done, 1'b0); end
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b1) begin n_fail++; $display("FAIL full8_done2 got %b exp %b", operation_done, 1'b1); end
        n_tests++; if (data_out !== 32'hB) begin n_fail++; $display("FAIL full8_single_data got %h exp %h", data_out, 32'hB); end
        n_tests++; if (num_of_errors !== 2'b01) begin n_fail++; $display("FAIL full8_single_nerr got %b exp %b", num_of_errors, 2'b01); end
        start_op(32'h0, 32'h3, 32'hB, 32'h2);
        repeat (2) @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL full8_double_data got %h exp %h", data_out, 32'h0); end
        n_tests++; if (num_of_errors !== 2'b10) begin n_fail++; $display("FAIL full8_double_nerr got %b exp %b", num_of_errors, 2'b10); end
        start_op(32'h2, 32'h8000_0000, 32'h03FF_FFFF, 32'h2);
        repeat (2) @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'h03FF_FFFF) begin n_fail++; $display("FAIL full32_data got %h exp %h", data_out, 32'h03FF_FFFF); end
        n_tests++; if (num_of_errors !== 2'b01) begin n_fail++; $display("FAIL full32_nerr got %b exp %b", num_of_errors, 2'b01); end
        start_op(32'h0, 32'h0, 32'hB, 32'h3);
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL mode3_done1 got %b exp %b", operation_done, 1'b0); end
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b1) begin n_fail++; $display("FAIL mode3_done2 got %b exp %b", operation_done, 1'b1); end
        n_tests++; if (num_of_errors !== 2'b00) begin n_fail++; $display("FAIL mode3_nerr got %b exp %b", num_of_errors, 2'b00); end
    endtask

    task automatic test_busy_write();
        logic        err;
        logic [31:0] rd;
        start_op(32'h0, 32'h0, 32'hB, 32'h2);
        apb_access(4'h4, 32'h5, err);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL busy_pslverr got %b exp %b", err, 1'b1); end
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b1) begin n_fail++; $display("FAIL busy_done got %b exp %b", operation_done, 1'b1); end
        n_tests++; if (data_out !== 32'hB) begin n_fail++; $display("FAIL busy_data got %h exp %h", data_out, 32'hB); end
        apb_access(4'h0, 32'h0, err);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL done_ctrl_pslverr got %b exp %b", err, 1'b1); end
        repeat (2) begin
            @(posedge PCLK); #1;
            n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL done_ctrl_ignored got %b exp %b", operation_done, 1'b0); end
        end
        apb_read(4'h4, rd, err);
        n_tests++; if (rd !== 32'hB) begin n_fail++; $display("FAIL busy_datain_reg got %h exp %h", rd, 32'hB); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL read_pslverr got %b exp %b", err, 1'b0); end
        apb_read(4'h0, rd, err);
        n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL done_ctrl_reg got %h exp %h", rd, 32'h2); end
    endtask

    task automatic test_reset_midop();
        start_op(32'h0, 32'h0, 32'hB, 32'h2);
        @(posedge PCLK); #1;
        n_tests++; if (data_out !== 32'hB) begin n_fail++; $display("FAIL midop_pre_data got %h exp %h", data_out, 32'hB); end
        #2 PRESETn = 1'b0;
        #1;
        n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL midop_rst_data got %h exp %h", data_out, 32'h0); end
        n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL midop_rst_done got %b exp %b", operation_done, 1'b0); end
        apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = 20'h4;
        #1;
        n_tests++; if (apb.PRDATA !== 32'h0) begin n_fail++; $display("FAIL midop_rst_reg got %h exp %h", apb.PRDATA, 32'h0); end
        idle_bus();
        @(negedge PCLK) PRESETn = 1'b1;
        repeat (3) begin
            @(posedge PCLK); #1;
            n_tests++; if (operation_done !== 1'b0) begin n_fail++; $display("FAIL midop_no_done got %b exp %b", operation_done, 1'b0); end
        end
        start_op(32'h0, 32'h0, 32'hB, 32'h0);
        @(posedge PCLK); #1;
        n_tests++; if (operation_done !== 1'b1) begin n_fail++; $display("FAIL post_rst_done got %b exp %b", operation_done, 1'b1); end
        n_tests++; if (data_out !== 32'h1B) begin n_fail++; $display("FAIL post_rst_data got %h exp %h", data_out, 32'h1B); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_full();
        test_busy_write();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ecc_apb_engine.md
ECC_APB_ENGINE -- requirements
Module: ecc_apb_engine

Interface
REQ-001 Parameter AMBA_WORD, default 32, APB data width and register width.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 Parameter DATA_WIDTH, default 32, width of data_out; SHALL be >= 32.
REQ-004 PCLK  in  1  single clock; all logic rising-edge.
REQ-005 PRESETn  in  1  asynchronous active-low reset.
REQ-006 PADDR  in  AMBA_ADDR_WIDTH  APB address; only PADDR[3:2] decoded.
REQ-007 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-008 PWDATA  in  AMBA_WORD  APB write data.
REQ-009 PRDATA  out  AMBA_WORD  APB read data.
REQ-010 PREADY  out  1  tied 1 (zero wait states).
REQ-011 PSLVERR  out  1  access error.
REQ-012 data_out  out  DATA_WIDTH  operation result, zero-extended.
REQ-013 operation_done  out  1  one-cycle completion pulse.
REQ-014 num_of_errors  out  2  00 none, 01 single, 10 double; 11 never driven.

Function
REQ-015 Registers at PADDR[3:2]: 00 CTRL, 01 DATA_IN, 10 CODEWORD_WIDTH, 11 NOISE; write on PSEL&PENABLE&PWRITE rising edge.
REQ-016 PRDATA SHALL return addressed register combinationally when PSEL&!PWRITE, else 0.
REQ-017 CTRL[1:0]: 00 encode, 01 decode, 10 full channel (encode, XOR NOISE, decode); 11 treated as full channel.
REQ-018 CODEWORD_WIDTH[1:0]: 00 -> W=8,K=4,P=4; 01 -> W=16,K=11,P=5; 10/11 -> W=32,K=26,P=6.
REQ-019 Data bit j SHALL map to the j-th non-power-of-two position number >= 3 (3,5,6,7,9,...).
REQ-020 Parity Ci (i=0..P-2) = XOR of data bits whose position number has bit i set; overall parity = XOR of all data and Ci.
REQ-021 Codeword layout {overall, C(P-2)..C0, data[K-1:0]}, bits above W zero.
REQ-022 Decode: syndrome s = received Ci XOR recomputed Ci; ov = XOR of all W received bits.
REQ-023 s=0,ov=0 -> 00, data unchanged; ov=1 -> 01, flip bit at position s (s=0 flips overall bit); ov=0,s!=0 -> 10, data_out = 0.
REQ-024 Decode data_out = corrected data[K-1:0] zero-extended; encode data_out = codeword zero-extended, num_of_errors = 00.
REQ-025 Write to CTRL while IDLE SHALL start an operation, sampling DATA_IN, CODEWORD_WIDTH, NOISE at that edge.
REQ-026 FSM states IDLE, ENC, DEC, DONE: encode IDLE->ENC->DONE; decode IDLE->DEC->DONE; full IDLE->ENC->DEC->DONE; DONE->IDLE unconditionally.
REQ-027 operation_done SHALL be 1 exactly in the DONE cycle; latency from CTRL write edge: encode/decode 2 cycles, full 3 cycles.
REQ-028 data_out and num_of_errors SHALL update on entry to DONE and hold until the next DONE.
REQ-029 Any write while not IDLE SHALL be ignored and assert PSLVERR for that access phase; reads allowed anytime with PSLVERR=0.
REQ-030 DATA_IN bits above K (encode) or above W (decode) SHALL be ignored.
REQ-031 Write to CTRL and DONE in same cycle: write rejected per REQ-029.

Reset
REQ-032 PRESETn low SHALL immediately force FSM IDLE, all registers 0, data_out 0, num_of_errors 00, operation_done 0, PSLVERR 0, regardless of operation in progress.
REQ-033 After release, first CTRL write SHALL start normally; no pending operation survives reset.

Verification
REQ-034 W=8, DATA_IN=0xB, CTRL=00 -> operation_done 2 cycles later, data_out=0x1B, num_of_errors=00.
REQ-035 W=8, DATA_IN=0x1B, CTRL=01 -> data_out=0xB, num_of_errors=00 after 2 cycles.
REQ-036 W=8, DATA_IN=0xB, NOISE=0x01, CTRL=10 -> after 3 cycles data_out=0xB, num_of_errors=01; NOISE=0x03 -> data_out=0, num_of_errors=10.
REQ-037 W=32, DATA_IN=0x3FFFFFF, NOISE=0x80000000, CTRL=10 -> data_out=0x3FFFFFF, num_of_errors=01.
REQ-038 Write DATA_IN during ENC -> PSLVERR=1, register unchanged, result per original DATA_IN.
REQ-039 Assert PRESETn low during DEC -> all outputs 0 asynchronously, no operation_done pulse after release.
